if_fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the IF/DC pipeline register.
- Holds the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small in-order fetch queue and presents them as new_inst/new_pc.
- Honours the hazard unit's is_stay back-pressure and flushes on branch/jump redirects from execute.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/if_fetch_unit.sv | 104 ++++++++++
 tb/tb_if_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path definitions: word type, fetch-queue entry and reset constants.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;

  localparam word_t NOP_INST_DEFAULT = 32'h0000_0013;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must keep pushes away from a full FIFO.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      assert (!(push && full)) else $error("fetch_fifo push while full");
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, in-order fetch queue.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter word_t       RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter word_t       NOP_INST        = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        is_stay,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        new_valid,
  output logic [31:0] new_inst,
  output logic [31:0] new_pc
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QCNT_W = $clog2(QUEUE_DEPTH + 1);

  word_t             fetch_pc;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  discard;
  logic [QCNT_W-1:0] queue_count;
  logic [OUT_W-1:0]  tag_count_unused;
  logic              redirect_lsb_unused;
  word_t             tag_head;
  fetch_entry_t      entry_in;
  fetch_entry_t      entry_head;
  logic              grant;
  logic              rsp;
  logic              keep_rsp;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign imem_req = resetn && !redirect_valid
                 && ((32'(queue_count) + 32'(outstanding)) < QUEUE_DEPTH)
                 && (32'(outstanding) < MAX_OUTSTANDING);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign rsp       = resetn && imem_rvalid && (outstanding != '0);
  assign keep_rsp  = rsp && (discard == '0) && !redirect_valid;

  // Every response still owed after a redirect belongs to the old path.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(grant) - OUT_W'(rsp);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        discard  <= outstanding - OUT_W'(rsp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && (discard != '0)) discard <= discard - OUT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_tags (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (keep_rsp),
    .head_data (tag_head),
    .count     (tag_count_unused)
  );

  assign entry_in.inst = imem_rdata;
  assign entry_in.pc   = tag_head;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (keep_rsp),
    .push_data (entry_in),
    .pop       (new_valid && !is_stay),
    .head_data (entry_head),
    .count     (queue_count)
  );

  assign new_valid = (queue_count != '0);
  assign new_inst  = new_valid ? entry_head.inst : NOP_INST;
  assign new_pc    = new_valid ? entry_head.pc   : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic against a queue-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned QD  = 2;
  localparam int unsigned MO  = 2;

  logic        clk;
  logic        resetn;
  logic        is_stay;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        new_valid;
  logic [31:0] new_inst;
  logic [31:0] new_pc;

  if_fetch_unit #(
    .RESET_PC        (RPC),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO),
    .NOP_INST        (NOP)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .is_stay        (is_stay),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .new_valid      (new_valid),
    .new_inst       (new_inst),
    .new_pc         (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        pend[$];
  ent_t        fq[$];
  logic [31:0] popped[$];
  logic [31:0] issue_pc = RPC;
  logic [31:0] salt;
  int unsigned cyc = 0;
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 1;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rstn, input bit stay, input bit redir,
                      input logic [31:0] rpc, input bit gnt, input bit stray);
    bit          rsp;
    bit          exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    req_t        r;
    ent_t        e;
    @(negedge clk);
    rsp            = (pend.size() != 0) && (pend[0].due <= cyc);
    resetn         = rstn;
    is_stay        = stay;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    imem_rvalid    = rsp || stray;
    imem_rdata     = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_req  = rstn && !redir && (pend.size() + fq.size() < QD) && (pend.size() < MO);
    exp_pc   = (fq.size() != 0) ? fq[0].pc : 32'h0;
    exp_inst = (fq.size() != 0) ? fq[0].inst : NOP;
    s_req = imem_req; s_addr = imem_addr; s_valid = new_valid; s_pc = new_pc; s_inst = new_inst;
    vectors++;
    assert (imem_req === exp_req) else begin
      miscompares++;
      $error("FAIL imem_req @%0d: got %b expected %b", cyc, imem_req, exp_req);
    end
    if (exp_req) begin
      assert (imem_addr === issue_pc) else begin
        miscompares++;
        $error("FAIL imem_addr @%0d: got %h expected %h", cyc, imem_addr, issue_pc);
      end
    end
    assert (new_valid === (fq.size() != 0)) else begin
      miscompares++;
      $error("FAIL new_valid @%0d: got %b expected %b", cyc, new_valid, fq.size() != 0);
    end
    assert (new_pc === exp_pc) else begin
      miscompares++;
      $error("FAIL new_pc @%0d: got %h expected %h", cyc, new_pc, exp_pc);
    end
    assert (new_inst === exp_inst) else begin
      miscompares++;
      $error("FAIL new_inst @%0d: got %h expected %h", cyc, new_inst, exp_inst);
    end
    if (!rstn) begin
      pend.delete();
      fq.delete();
      issue_pc = RPC;
    end else begin
      if (fq.size() != 0 && !stay) begin
        popped.push_back(fq[0].pc);
        void'(fq.pop_front());
      end
      if (rsp) begin
        r = pend.pop_front();
        if (!r.stale && !redir) begin
          e.pc = r.addr; e.inst = mem_word(r.addr);
          fq.push_back(e);
        end
      end
      if (exp_req && gnt) begin
        r.addr = issue_pc; r.due = cyc + $urandom_range(lat_hi, lat_lo); r.stale = 1'b0;
        pend.push_back(r);
        issue_pc += 32'd4;
      end
      if (redir) begin
        fq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        issue_pc = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_addr;
    salt = $urandom;
    resetn = 1'b0; is_stay = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 1, 1);
    check32("reset_req", 32'(s_req), 0);
    check32("reset_pc", s_pc, 32'h0);
    check32("reset_inst", s_inst, NOP);

    // streaming from RESET_PC
    step(1, 0, 0, 0, 1, 0);
    check32("first_addr", s_addr, RPC);
    check32("first_req", 32'(s_req), 1);
    popped.delete();
    repeat (14) step(1, 0, 0, 0, 1, 0);
    check32("stream_pc0", popped[0], 32'h0);
    check32("stream_pc1", popped[1], 32'h4);
    check32("stream_pc2", popped[2], 32'h8);

    // downstream stall with queue filling
    repeat (4) step(1, 1, 0, 0, 1, 0);
    hold_pc = s_pc;
    step(1, 1, 0, 0, 1, 0);
    check32("stay_head", s_pc, hold_pc);
    check32("stay_req", 32'(s_req), 0);
    check32("stay_valid", 32'(s_valid), 1);
    repeat (6) step(1, 0, 0, 0, 1, 0);

    // redirect with two old-path requests in flight
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && pend.size() < 2; i++) step(1, 0, 0, 0, 1, 0);
    check32("pend_before_redirect", pend.size(), 2);
    step(1, 0, 1, 32'h0000_0102, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    check32("redirect_addr", s_addr, 32'h0000_0100);
    popped.delete();
    for (int i = 0; i < 12 && popped.size() == 0; i++) step(1, 0, 0, 0, 1, 0);
    check32("redirect_first_pc", popped.size() ? popped[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // grant withheld: address holds, queue drains to NOP
    lat_lo = 1; lat_hi = 1;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    hold_addr = s_addr;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check32("nognt_addr", s_addr, hold_addr);
    check32("nognt_valid", 32'(s_valid), 0);
    check32("nognt_inst", s_inst, NOP);

    // PC wrap at the top of the address space
    step(1, 0, 1, 32'hFFFF_FFFE, 1, 0);
    check32("wrap_addr", s_addr, hold_addr);
    popped.delete();
    repeat (10) step(1, 0, 0, 0, 1, 0);
    check32("wrap_pc0", popped[0], 32'hFFFF_FFFC);
    check32("wrap_pc1", popped[1], 32'h0000_0000);

    // mid-stream reset with one request outstanding, then a stray response
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 10 && pend.size() != 1; i++) step(1, 0, 0, 0, 1, 0);
    check32("pend_before_reset", pend.size(), 1);
    step(0, 0, 0, 0, 1, 0);
    check32("midreset_req", 32'(s_req), 0);
    step(1, 0, 0, 0, 1, 1);
    check32("postreset_valid", 32'(s_valid), 0);
    check32("postreset_pc", s_pc, 32'h0);
    check32("postreset_addr", s_addr, RPC);
    repeat (8) step(1, 0, 0, 0, 1, 0);

    // random traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      step(1, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
           $urandom_range(0, 3) != 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
